// File: rtl/rst_seq_pkg.sv
// Shared types and encodings for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StHold,
    StCount,
    StRelease,
    StRun
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;

  // Counter width able to hold values up to max_val - 1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// External reset pin synchronizer and saturating low-level debouncer.
module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ext_rst_ni,
  output logic ext_hold_o
);

  localparam int unsigned    CntW   = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ext_rst_ni;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Flag on the edge that completes the run of low samples, so the FSM acts on that same edge.
  assign ext_hold_o = !sync2_q && (cnt_d == CntMax);

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: POR delay, external/soft reset hold and ordered stage release.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned POR_CYCLES       = 5000,
  parameter int unsigned DEBOUNCE_CYCLES  = 1000,
  parameter int unsigned STAGE_GAP        = 64,
  parameter int unsigned NUM_STAGES       = 3,
  parameter int unsigned SOFT_HOLD_CYCLES = 16
) (
  input  logic                  i_clk_50m,
  input  logic                  i_rst_n,
  input  logic                  i_ext_rst_n,
  input  logic                  i_soft_rst,
  output logic [NUM_STAGES-1:0] o_rst_n,
  output logic                  o_ready,
  output logic [1:0]            o_rst_cause
);

  localparam int unsigned MaxAB   = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
  localparam int unsigned MaxCnt  = (MaxAB > SOFT_HOLD_CYCLES) ? MaxAB : SOFT_HOLD_CYCLES;
  localparam int unsigned CntW    = cnt_width(MaxCnt);
  localparam logic [CntW-1:0] PorLast  = CntW'(POR_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);
  localparam logic [CntW-1:0] SoftLast = CntW'(SOFT_HOLD_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]  rst_q, rst_d, rst_shift;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;
  logic                   ext_hold;
  logic                   reset_evt;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i      (i_clk_50m),
    .rst_ni     (i_rst_n),
    .ext_rst_ni (i_ext_rst_n),
    .ext_hold_o (ext_hold)
  );

  assign reset_evt = ext_hold || i_soft_rst;
  // Next stage pattern: one more bit released, strictly in ascending order.
  assign rst_shift = (rst_q << 1) | NUM_STAGES'(1);

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StCount;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold: begin
        if (cnt_q == SoftLast) state_d = StCount;
      end
      StCount: begin
        if (cnt_q == PorLast) state_d = (NUM_STAGES == 1) ? StRun : StRelease;
      end
      StRelease: begin
        if ((cnt_q == GapLast) && (&rst_shift)) state_d = StRun;
      end
      StRun: state_d = StRun;
      default: state_d = StCount;
    endcase
    if (reset_evt) state_d = StHold;
  end

  always_comb begin
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    unique case (state_q)
      StHold: begin
        cnt_d = (cnt_q == SoftLast) ? '0 : cnt_q + CntW'(1);
      end
      StCount: begin
        if (cnt_q == PorLast) begin
          cnt_d   = '0;
          rst_d   = NUM_STAGES'(1);
          ready_d = (NUM_STAGES == 1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          rst_d   = rst_shift;
          ready_d = &rst_shift;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: cnt_d = '0;
      default: cnt_d = '0;
    endcase
    // External source wins the cause when both fire together.
    if (reset_evt) begin
      cnt_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
      cause_d = ext_hold ? CAUSE_EXT : CAUSE_SOFT;
    end
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign o_rst_n     = rst_q;
  assign o_ready     = ready_q;
  assign o_rst_cause = cause_q;

endmodule
